pcpu_run_ctrl: RTL
==================

// Module: pcpu_run_ctrl
// PURPOSE
//  Run/debug sequencer for the 5-stage pipelined CPU. Drives the CPU enable/start pins to implement
//  free-run, single-step, pause, one PC breakpoint and HALT drain. Counts pipeline-advance cycles.
//  Sits between the board switches/debug host and PCPU, sharing its clock and reset.
// PARAMETERS
//  CNT_W      32  width of adv_count
//  DRAIN_CYC  3   advances after HALT fetch until HALT is in WB (id->ex->mem->wb)
// PORTS
//  clock      in   1      system clock, all state on posedge
//  reset      in   1      synchronous, active-high; same reset as the CPU
//  run_req    in   1      level/pulse: start or resume free-run
//  step_req   in   1      pulse: advance the pipeline exactly once
//  pause_req  in   1      pulse: stop free-run
//  bp_en      in   1      breakpoint enable
//  bp_addr    in   8      breakpoint PC
//  i_addr     in   8      CPU fetch address (CPU pc)
//  i_datain   in   16     instruction word being fetched
//  cpu_enable out  1      to CPU enable
//  cpu_start  out  1      to CPU start
//  cpu_exec   out  1      shadow of the CPU idle/exec state; 1 = pipeline advances at this edge
//  run_state  out  3      current controller state encoding
//  bp_hit     out  1      one-cycle pulse on breakpoint stop
//  halted     out  1      1 in HALTED
//  adv_count  out  CNT_W  number of edges with cpu_exec=1
// BEHAVIOUR
//  Shadow: cpu_exec <= cpu_enable & (cpu_start | cpu_exec). It mirrors the CPU state register exactly.
//  States: IDLE(0) RUN(1) STEP(2) STOPPED(3) DRAIN(4) HALTED(5). All are registered. Reset -> IDLE.
//  Reset values: all outputs 0, adv_count=0.
//  en_q = (state is RUN, STEP or DRAIN).
//  cpu_start = en_q. cpu_enable = en_q & ~stop_now (combinational gate, so stop takes effect this cycle).
//  halt_f = cpu_exec & (i_datain[`I_OP]==`HALT) & state in {RUN,STEP}.
//  bp_m   = cpu_exec & bp_en & (i_addr==bp_addr) & state==RUN.
//  stop_now = bp_m | (pause_req & state==RUN). halt_f does not gate enable.
//  Priority within a cycle: halt_f > bp_m > pause_req > run_req > step_req.
//  IDLE/STOPPED: run_req -> RUN; else step_req & ~cpu_exec -> STEP. A step is ignored while cpu_exec=1.
//  RUN:     halt_f -> DRAIN (cnt=DRAIN_CYC); bp_m -> STOPPED with bp_hit=1 next cycle; pause_req -> STOPPED.
//  STEP:    lasts exactly 1 cycle -> STOPPED (or DRAIN if halt_f).
//           CPU goes idle->exec at that edge, advances once on the next edge, then returns to idle.
//  DRAIN:   cnt decrements on each cpu_exec edge; at cnt==0 -> HALTED. run/step/pause/bp are ignored.
//  HALTED:  enable and start are low; terminal until reset. halted=1.
//  Stop semantics:
//   - CPU in exec with enable dropped performs exactly one more advance and goes idle.
//   - bp stop: the word at bp_addr is latched into id, and the CPU pc becomes bp_addr+1 (or the jump target).
//   - The resume edge fetches from pc != bp_addr, so there is no re-trigger unless the code loops back.
//  adv_count: +1 on every edge with cpu_exec=1; wraps modulo 2^CNT_W; never cleared except by reset.
//  Reset mid-run: IDLE next edge, enable low immediately after the edge, counters cleared, bp_hit cleared.
// STRUCTURE
//  Add to the shared header: state encodings `RC_IDLE..`RC_HALTED and `RC_DRAIN_CYC.
//  Reuse the existing `I_OP and `HALT from the header.
//  No sub-module. One FSM block, one shadow/counter block, one combinational output block.
// TESTING
//  1 reset; run_req pulse at t0 -> cpu_enable=cpu_start=1 at t0+1, cpu_exec=1 at t0+2, adv_count=1 at t0+3.
//  2 STOPPED, step_req one pulse -> exactly one cpu_exec=1 edge; adv_count +1; CPU pc +1; state STOPPED.
//    A second step_req while cpu_exec=1 is ignored.
//  3 RUN, bp_en=1, bp_addr=8'h05, straight-line code -> bp_hit pulse; cpu_enable=0 in the cycle i_addr==5.
//    CPU stops with pc=6 and id_ir=mem[5]. run_req resumes without re-hit.
//  4 HALT at addr 3 -> DRAIN for 3 advances; halted=1; CPU wb_ir holds HALT; run_req/step_req then have no effect.
//  5 Same cycle halt_f and pause_req (and bp_m at HALT's address) -> DRAIN wins, no bp_hit.
//    run_req+step_req together in STOPPED -> RUN.
//  6 Reset asserted in RUN and in DRAIN -> IDLE, adv_count=0, all outputs 0 the cycle after.
//    adv_count at 2^CNT_W-1 (CNT_W=4 build) wraps to 0.

Source files
------------

// File: rtl/pcpu_run_ctrl_pkg.sv
// ============================================================================
//  Module      : pcpu_run_ctrl_pkg
//  Description : Shared definitions for the PCPU run/debug sequencer:
//                controller state encodings, HALT drain length and the
//                instruction opcode field / HALT opcode decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pcpu_run_ctrl_pkg;

  // Controller state encoding (visible on run_state).
  typedef enum logic [2:0] {
    RC_IDLE    = 3'd0,
    RC_RUN     = 3'd1,
    RC_STEP    = 3'd2,
    RC_STOPPED = 3'd3,
    RC_DRAIN   = 3'd4,
    RC_HALTED  = 3'd5
  } rc_state_e;

  // Advances after the HALT fetch until HALT reaches WB (id->ex->mem->wb).
  localparam int RC_DRAIN_CYC = 3;

  // Opcode field of a 16-bit instruction word and the HALT opcode.
  localparam int         I_OP_MSB = 15;
  localparam int         I_OP_LSB = 11;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[I_OP_MSB:I_OP_LSB] == OP_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcpu_run_ctrl_if.sv
// ============================================================================
//  Module      : pcpu_run_ctrl_if
//  Description : Bundle between the debug host / CPU fetch port and the run
//                controller.
//                Host -> ctrl : run_req, step_req, pause_req, bp_en, bp_addr
//                CPU  -> ctrl : i_addr (fetch pc), i_datain (fetched word)
//                ctrl -> CPU  : cpu_enable, cpu_start
//                ctrl -> host : cpu_exec, run_state, bp_hit, halted, adv_count
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pcpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_req;
  logic             step_req;
  logic             pause_req;
  logic             bp_en;
  logic [7:0]       bp_addr;
  logic [7:0]       i_addr;
  logic [15:0]      i_datain;
  logic             cpu_enable;
  logic             cpu_start;
  logic             cpu_exec;
  logic [2:0]       run_state;
  logic             bp_hit;
  logic             halted;
  logic [CNT_W-1:0] adv_count;

  // Host/CPU side.
  modport master (
    output run_req, step_req, pause_req, bp_en, bp_addr, i_addr, i_datain,
    input  cpu_enable, cpu_start, cpu_exec, run_state, bp_hit, halted, adv_count
  );

  // Controller side.
  modport slave (
    input  run_req, step_req, pause_req, bp_en, bp_addr, i_addr, i_datain,
    output cpu_enable, cpu_start, cpu_exec, run_state, bp_hit, halted, adv_count
  );
endinterface

`default_nettype wire

// File: rtl/pcpu_run_ctrl.sv
// ============================================================================
//  Module      : pcpu_run_ctrl
//  Description : Run/debug sequencer for the 5-stage pipelined CPU. Drives the
//                CPU enable/start pins for free-run, single-step, pause, one
//                PC breakpoint and HALT drain; counts pipeline advances.
//  Ports       : clock  - system clock, all state on posedge
//                reset  - synchronous active-high, shared with the CPU
//                bus    - pcpu_run_ctrl_if.slave (requests, fetch port,
//                         CPU pins, status and advance counter)
//  Parameters  : CNT_W     - width of adv_count
//                DRAIN_CYC - advances after HALT fetch until HALT is in WB
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcpu_run_ctrl
  import pcpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = RC_DRAIN_CYC
) (
  input  logic              clock,
  input  logic              reset,
  pcpu_run_ctrl_if.slave    bus
);

  localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  rc_state_e        r_state;
  logic [DCW-1:0]   r_drain_cnt;
  logic             r_bp_hit;
  logic             r_halted;
  logic             r_exec;
  logic [CNT_W-1:0] r_adv;

  logic w_en_q;
  logic w_halt_f;
  logic w_bp_m;
  logic w_stop_now;
  logic w_enable;
  logic w_start;

  // --------------------------------------------------------------------------
  // Combinational CPU pin generation. enable is gated in the same cycle as a
  // breakpoint/pause so the CPU performs exactly one more advance and idles.
  // A HALT fetch does not gate enable: the pipeline must keep draining.
  // --------------------------------------------------------------------------
  always_comb begin
    w_en_q     = (r_state == RC_RUN) || (r_state == RC_STEP) || (r_state == RC_DRAIN);
    w_halt_f   = r_exec && is_halt(bus.i_datain) &&
                 ((r_state == RC_RUN) || (r_state == RC_STEP));
    w_bp_m     = r_exec && bus.bp_en && (bus.i_addr == bus.bp_addr) && (r_state == RC_RUN);
    w_stop_now = w_bp_m || (bus.pause_req && (r_state == RC_RUN));
    w_start    = w_en_q;
    w_enable   = w_en_q && !w_stop_now;
  end

  // --------------------------------------------------------------------------
  // Shadow of the CPU idle/exec register and the advance counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_exec <= 1'b0;
      r_adv  <= '0;
    end else begin
      r_exec <= w_enable && (w_start || r_exec);
      if (r_exec) begin
        r_adv <= r_adv + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM. Priority inside RUN: halt_f > bp_m > pause_req.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RC_IDLE;
      r_drain_cnt <= '0;
      r_bp_hit    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_bp_hit <= 1'b0;
      case (r_state)
        RC_IDLE, RC_STOPPED: begin
          if (bus.run_req) begin
            r_state <= RC_RUN;
          end else if (bus.step_req && !r_exec) begin
            // A step is only accepted once the previous advance has retired.
            r_state <= RC_STEP;
          end
        end
        RC_RUN: begin
          if (w_halt_f) begin
            r_state     <= RC_DRAIN;
            r_drain_cnt <= DCW'(DRAIN_CYC);
          end else if (w_bp_m) begin
            r_state  <= RC_STOPPED;
            r_bp_hit <= 1'b1;
          end else if (bus.pause_req) begin
            r_state <= RC_STOPPED;
          end
        end
        RC_STEP: begin
          if (w_halt_f) begin
            r_state     <= RC_DRAIN;
            r_drain_cnt <= DCW'(DRAIN_CYC);
          end else begin
            r_state <= RC_STOPPED;
          end
        end
        RC_DRAIN: begin
          // Count only real advances; the edge that consumes the last one
          // moves to HALTED so HALT ends up in WB.
          if (r_drain_cnt == '0) begin
            r_state  <= RC_HALTED;
            r_halted <= 1'b1;
          end else if (r_exec) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
            if (r_drain_cnt == DCW'(1)) begin
              r_state  <= RC_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        RC_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= RC_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_enable = w_enable;
  assign bus.cpu_start  = w_start;
  assign bus.cpu_exec   = r_exec;
  assign bus.run_state  = r_state;
  assign bus.bp_hit     = r_bp_hit;
  assign bus.halted     = r_halted;
  assign bus.adv_count  = r_adv;

endmodule

`default_nettype wire
